// File: rtl/i2c_xfer_sequencer.sv
// Round-robin arbiter and command sequencer sharing one byte-level I2C master
// core between NUM_REQ register-transaction requesters.
module i2c_xfer_sequencer #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [7*NUM_REQ-1:0]   req_dev,
    input  logic [8*NUM_REQ-1:0]   req_reg,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_nack,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic                   m_cmd_valid,
    input  logic                   m_cmd_ready,
    output logic [1:0]             m_cmd,
    output logic [7:0]             m_cmd_data,
    output logic                   m_cmd_nack,
    input  logic                   m_rsp_valid,
    input  logic [7:0]             m_rsp_data,
    input  logic                   m_rsp_nack,
    output logic                   m_abort
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, START, DEVW, REG, DATA, RSTART, DEVR, READ, STOP, RESP
    } state_t;

    state_t          state, state_nx;
    logic            issued, issued_nx;     // command accepted, awaiting core response
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   own, own_nx;
    logic            rw, rw_nx;
    logic [6:0]      dev, dev_nx;
    logic [7:0]      reg_a, reg_nx;
    logic [7:0]      wdata, wdata_nx;
    logic [7:0]      rdata, rdata_nx;
    logic            nack, nack_nx;
    logic            to_flag, to_nx;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;

    // State and transaction context registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state   <= IDLE;
            issued  <= 1'b0;
            cnt     <= '0;
            ptr     <= '0;
            own     <= '0;
            rw      <= 1'b0;
            dev     <= '0;
            reg_a   <= '0;
            wdata   <= '0;
            rdata   <= '0;
            nack    <= 1'b0;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nx;
            issued  <= issued_nx;
            cnt     <= cnt_nx;
            ptr     <= ptr_nx;
            own     <= own_nx;
            rw      <= rw_nx;
            dev     <= dev_nx;
            reg_a   <= reg_nx;
            wdata   <= wdata_nx;
            rdata   <= rdata_nx;
            nack    <= nack_nx;
            to_flag <= to_nx;
        end
    end

    // Arbitration, command sequencing, timeout and response generation
    always_comb begin
        state_nx    = state;
        issued_nx   = issued;
        cnt_nx      = cnt;
        ptr_nx      = ptr;
        own_nx      = own;
        rw_nx       = rw;
        dev_nx      = dev;
        reg_nx      = reg_a;
        wdata_nx    = wdata;
        rdata_nx    = rdata;
        nack_nx     = nack;
        to_nx       = to_flag;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_rdata   = '0;
        rsp_nack    = 1'b0;
        rsp_timeout = 1'b0;
        busy        = 1'b0;
        m_cmd_valid = 1'b0;
        m_cmd       = CMD_START;
        m_cmd_data  = '0;
        m_cmd_nack  = 1'b0;
        m_abort     = 1'b0;
        gnt_found   = 1'b0;
        gnt_idx     = '0;
        cand        = '0;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(ptr) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end

        case (state)
            IDLE: begin
                // Gated by reset so no accept pulse escapes while the reset net is low
                if (gnt_found && s00_axi_aresetn) begin
                    req_ready[gnt_idx] = 1'b1;
                    busy      = 1'b1;
                    own_nx    = gnt_idx;
                    rw_nx     = req_rw[gnt_idx];
                    dev_nx    = req_dev[7*gnt_idx +: 7];
                    reg_nx    = req_reg[8*gnt_idx +: 8];
                    wdata_nx  = req_wdata[8*gnt_idx +: 8];
                    ptr_nx    = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_nx  = START;
                    issued_nx = 1'b0;
                    cnt_nx    = '0;
                end
            end
            RESP: begin
                busy           = 1'b1;
                rsp_valid[own] = 1'b1;
                rsp_nack       = nack;
                rsp_timeout    = to_flag;
                rsp_rdata      = (rw && !nack && !to_flag) ? rdata : 8'h00;
                state_nx       = IDLE;
                nack_nx        = 1'b0;
                to_nx          = 1'b0;
                rdata_nx       = '0;
                cnt_nx         = '0;
            end
            default: begin
                busy        = 1'b1;
                m_cmd_valid = !issued;
                case (state)
                    START, RSTART: m_cmd = CMD_START;
                    DEVW: begin m_cmd = CMD_WRITE; m_cmd_data = {dev, 1'b0}; end
                    REG:  begin m_cmd = CMD_WRITE; m_cmd_data = reg_a;       end
                    DATA: begin m_cmd = CMD_WRITE; m_cmd_data = wdata;       end
                    DEVR: begin m_cmd = CMD_WRITE; m_cmd_data = {dev, 1'b1}; end
                    READ: begin m_cmd = CMD_READ;  m_cmd_nack = 1'b1;        end
                    default: m_cmd = CMD_STOP;
                endcase

                if (cnt == CW'(TIMEOUT_CYC)) begin
                    // Abort skips STOP entirely; the core releases the bus itself
                    m_cmd_valid = 1'b0;
                    m_abort     = 1'b1;
                    to_nx       = 1'b1;
                    state_nx    = RESP;
                    issued_nx   = 1'b0;
                    cnt_nx      = '0;
                end else if (issued && m_rsp_valid) begin
                    issued_nx = 1'b0;
                    cnt_nx    = '0;
                    case (state)
                        START:  state_nx = DEVW;
                        RSTART: state_nx = DEVR;
                        READ: begin
                            rdata_nx = m_rsp_data;
                            state_nx = STOP;
                        end
                        STOP:   state_nx = RESP;
                        default: begin
                            if (m_rsp_nack) begin
                                nack_nx  = 1'b1;
                                state_nx = STOP;
                            end else begin
                                case (state)
                                    DEVW:    state_nx = REG;
                                    REG:     state_nx = rw ? RSTART : DATA;
                                    DEVR:    state_nx = READ;
                                    default: state_nx = STOP;
                                endcase
                            end
                        end
                    endcase
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (!issued && m_cmd_ready) issued_nx = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench for i2c_xfer_sequencer with a small I2C core responder.
module tb_i2c_xfer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_rw = '0;
    logic [13:0] req_dev = '0;
    logic [15:0] req_reg = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack, rsp_timeout, busy;
    logic        m_cmd_valid;
    logic        m_cmd_ready = 1'b1;
    logic [1:0]  m_cmd;
    logic [7:0]  m_cmd_data;
    logic        m_cmd_nack;
    logic        m_rsp_valid = 1'b0;
    logic [7:0]  m_rsp_data = '0;
    logic        m_rsp_nack = 1'b0;
    logic        m_abort;

    i2c_xfer_sequencer #(.NUM_REQ(2), .TIMEOUT_CYC(16)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd(m_cmd),
        .m_cmd_data(m_cmd_data), .m_cmd_nack(m_cmd_nack),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_nack(m_rsp_nack),
        .m_abort(m_abort)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [10:0] exp_cmd[$];   // {cmd, data, nack}
    logic [11:0] exp_rsp[$];   // {rsp_valid, rdata, nack, timeout}
    int          exp_gnt[$];

    // core responder controls
    logic        core_mute = 1'b0;
    logic        nack_en = 1'b0;
    logic [7:0]  nack_byte = '0;
    logic [7:0]  core_rdata = '0;
    logic        stall_en = 1'b0;
    logic [7:0]  stall_byte = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    task automatic push_cmd(input logic [1:0] c, input logic [7:0] d, input logic n);
        exp_cmd.push_back({c, d, n});
    endtask

    task automatic push_wr(input logic [7:0] devb, input logic [7:0] rg, input logic [7:0] wd);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b01, devb, 1'b0);
        push_cmd(2'b01, rg, 1'b0);
        push_cmd(2'b01, wd, 1'b0);
        push_cmd(2'b11, 8'h00, 1'b0);
    endtask

    task automatic issue(input int i, input logic rw, input logic [6:0] dv,
                         input logic [7:0] rg, input logic [7:0] wd);
        int n;
        req_rw[i]           = rw;
        req_dev[7*i +: 7]   = dv;
        req_reg[8*i +: 8]   = rg;
        req_wdata[8*i +: 8] = wd;
        req_valid[i]        = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 200);
        check("grant_wait", req_ready[i], 1'b1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, exp_rsp.size() + exp_cmd.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // core ready: withheld only for a chosen WRITE byte
    initial forever begin
        @(posedge clk);
        #1;
        m_cmd_ready = !(stall_en && m_cmd_valid && m_cmd == 2'b01 && m_cmd_data == stall_byte);
    end

    // core responder: answers each accepted command two cycles later
    initial forever begin
        logic [1:0] cc;
        logic [7:0] cd;
        @(negedge clk);
        if (rst_n && m_cmd_valid && m_cmd_ready) begin
            accept_cyc = cyc;
            cc = m_cmd;
            cd = m_cmd_data;
            if (!core_mute) begin
                repeat (2) @(posedge clk);
                #1;
                m_rsp_valid = 1'b1;
                m_rsp_data  = (cc == 2'b10) ? core_rdata : 8'h00;
                m_rsp_nack  = nack_en && cc == 2'b01 && cd == nack_byte;
                @(posedge clk);
                #1;
                m_rsp_valid = 1'b0;
                m_rsp_nack  = 1'b0;
                m_rsp_data  = 8'h00;
            end
        end
    end

    // command monitor
    initial forever begin
        logic [10:0] e;
        @(negedge clk);
        if (rst_n && m_cmd_valid && m_cmd_ready) begin
            if (exp_cmd.size() == 0) unexpected("cmd", {m_cmd, m_cmd_data, m_cmd_nack});
            else begin
                e = exp_cmd.pop_front();
                check("cmd", {m_cmd, m_cmd_data, m_cmd_nack}, e);
            end
        end
    end

    // grant monitor
    initial forever begin
        logic prev_mid = 1'b0;
        int   g;
        @(negedge clk);
        if (|req_ready) begin
            if (exp_gnt.size() == 0) unexpected("grant", req_ready);
            else begin
                g = exp_gnt.pop_front();
                check("grant", req_ready, 2'b01 << g);
            end
            check("grant_while_busy", prev_mid, 1'b0);
            check("busy_at_accept", busy, 1'b1);
        end
        prev_mid = busy && !(|rsp_valid);
    end

    // response monitor
    initial forever begin
        logic [11:0] e;
        @(negedge clk);
        if (|rsp_valid) begin
            if (exp_rsp.size() == 0) unexpected("rsp", {rsp_valid, rsp_rdata, rsp_nack, rsp_timeout});
            else begin
                e = exp_rsp.pop_front();
                check("rsp_valid", rsp_valid, e[11:10]);
                check("rsp_rdata", rsp_rdata, e[9:2]);
                check("rsp_nack", rsp_nack, e[1]);
                check("rsp_timeout", rsp_timeout, e[0]);
                check("rsp_busy", busy, 1'b1);
            end
        end
    end

    initial begin
        int n, g0, g1;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_cmd_valid", m_cmd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_nack, rsp_timeout}, 12'h000);
        check("rst_abort", m_abort, 1'b0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // write on requester 0
        exp_gnt.push_back(0);
        push_wr(8'hA0, 8'h10, 8'hA5);
        exp_rsp.push_back({2'b01, 8'h00, 1'b0, 1'b0});
        issue(0, 1'b0, 7'h50, 8'h10, 8'hA5);
        drain("write");

        // read on requester 1
        core_rdata = 8'h71;
        exp_gnt.push_back(1);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b01, 8'hD0, 1'b0);
        push_cmd(2'b01, 8'h75, 1'b0);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b01, 8'hD1, 1'b0);
        push_cmd(2'b10, 8'h00, 1'b1);
        push_cmd(2'b11, 8'h00, 1'b0);
        exp_rsp.push_back({2'b10, 8'h71, 1'b0, 1'b0});
        issue(1, 1'b1, 7'h68, 8'h75, 8'h00);
        drain("read");

        // device address NACK on requester 1
        nack_en = 1'b1;
        nack_byte = 8'hA0;
        exp_gnt.push_back(1);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b01, 8'hA0, 1'b0);
        push_cmd(2'b11, 8'h00, 1'b0);
        exp_rsp.push_back({2'b10, 8'h00, 1'b1, 1'b0});
        issue(1, 1'b0, 7'h50, 8'h22, 8'h33);
        drain("nack");
        nack_en = 1'b0;

        // both requesters held: grants alternate 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            exp_gnt.push_back(0);
            exp_gnt.push_back(1);
            push_wr(8'h22, 8'h01, 8'h02);
            push_wr(8'h44, 8'h03, 8'h04);
            exp_rsp.push_back({2'b01, 8'h00, 1'b0, 1'b0});
            exp_rsp.push_back({2'b10, 8'h00, 1'b0, 1'b0});
        end
        req_rw = 2'b00;
        req_dev = {7'h22, 7'h11};
        req_reg = {8'h03, 8'h01};
        req_wdata = {8'h04, 8'h02};
        req_valid = 2'b11;
        g0 = 0;
        g1 = 0;
        n = 0;
        while ((g0 < 2 || g1 < 2) && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
            @(posedge clk);
            #1;
            if (g0 >= 2) req_valid[0] = 1'b0;
            if (g1 >= 2) req_valid[1] = 1'b0;
        end
        req_valid = 2'b00;
        check("arb_grant_count", g0 + g1, 4);
        drain("arb");

        // timeout: core silent after START is accepted
        core_mute = 1'b1;
        exp_gnt.push_back(0);
        push_cmd(2'b00, 8'h00, 1'b0);
        exp_rsp.push_back({2'b01, 8'h00, 1'b0, 1'b1});
        issue(0, 1'b0, 7'h50, 8'h10, 8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_abort && n < 100);
        check("abort_seen", m_abort, 1'b1);
        check("abort_cycle", cyc - accept_cyc, 16);
        @(negedge clk);
        check("abort_pulse", m_abort, 1'b0);
        drain("timeout");
        core_mute = 1'b0;

        // async reset while DATA holds m_cmd_valid
        stall_byte = 8'h5A;
        stall_en = 1'b1;
        exp_gnt.push_back(0);
        push_cmd(2'b00, 8'h00, 1'b0);
        push_cmd(2'b01, 8'hA0, 1'b0);
        push_cmd(2'b01, 8'h10, 1'b0);
        issue(0, 1'b0, 7'h50, 8'h10, 8'h5A);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_cmd_valid && m_cmd_data == 8'h5A) && n < 100);
        check("stall_in_data", {m_cmd_valid, m_cmd, m_cmd_data}, {1'b1, 2'b01, 8'h5A});
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd_valid", m_cmd_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req_ready", req_ready, 2'b00);
        check("mid_rst_rsp_valid", rsp_valid, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b00;
        stall_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_cmd_queue", exp_cmd.size(), 0);

        // RR pointer back at 0; requester 1 withdraws before its turn
        exp_gnt.push_back(0);
        push_wr(8'h78, 8'h44, 8'h99);
        exp_rsp.push_back({2'b01, 8'h00, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        req_rw = 2'b00;
        req_dev = {7'h01, 7'h3C};
        req_reg = {8'h00, 8'h44};
        req_wdata = {8'h00, 8'h99};
        req_valid = 2'b11;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(|req_ready) && n < 50);
        check("post_rst_grant_seen", |req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("post_rst");
        repeat (5) @(negedge clk);
        check("grant_queue_empty", exp_gnt.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
